// File: rtl/sme_pkg.sv
// Shared constants and types for the SME matcher and its feeder stage.
package sme_pkg;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  // Wide enough for a saturated string length (33) and a full burst index (40).
  typedef logic [5:0] len_t;

  typedef enum logic [1:0] {
    COLLECT,
    ARMED,
    SEND,
    WAIT_RES
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/sme_char_buf.sv
// Byte register file: synchronous write at an internal write pointer, asynchronous read.
// clr_i restarts the pointer; a write in the same cycle lands at address 0.
module sme_char_buf #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [7:0]    head_o
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] wr_addr;

  assign wr_addr = clr_i ? '0 : wr_ptr_q;

  // NOTE: the storage is small and is cleared on reset so a record replayed
  // after reset can never expose stale bytes; large RAMs would not be reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (wr_addr < DEPTH_C)) begin
      mem_q[wr_addr[AW-1:0]] <= wr_data_i;
      wr_ptr_q               <= wr_addr + 1'b1;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];
  assign head_o    = mem_q[0];

endmodule

// File: rtl/sme_feeder.sv
// Buffers framed string/pattern records and replays them to SME as one contiguous burst
// aligned to an SME idle pulse, then forwards only the result belonging to that pattern.
module sme_feeder
  import sme_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_pat,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       err_len
);

  localparam int   SAW     = $clog2(STR_MAX);
  localparam int   PAW     = $clog2(PAT_MAX);
  localparam len_t STR_LIM = len_t'(STR_MAX + 1);
  localparam len_t PAT_LIM = len_t'(PAT_MAX + 1);

  state_e     state_q;
  logic       first_q, rec_pat_q, str_pending_q;
  len_t       rec_len_q, str_len_q, pat_len_q, ptr_q;
  logic [7:0] chardata_q;
  logic       isstring_q, ispattern_q;
  logic       res_valid_q, res_match_q, err_len_q;
  logic [4:0] res_index_q;

  logic           xfer, cur_pat, launch, rd_is_str;
  len_t           lim, len_d, slen, total, rd_idx;
  logic [SAW-1:0] str_addr;
  logic [PAW-1:0] pat_addr;
  logic [7:0]     str_rd, str_head, pat_rd, pat_head, nxt_byte;

  assign in_ready = (state_q == COLLECT);
  assign xfer     = in_valid && in_ready;

  // The record type is taken from the first byte and held for the rest of the record.
  assign cur_pat = first_q ? in_is_pat : rec_pat_q;
  assign lim     = cur_pat ? PAT_LIM : STR_LIM;
  assign len_d   = first_q ? len_t'(1) : ((rec_len_q == lim) ? lim : rec_len_q + len_t'(1));

  // Burst index k walks the pending string first, then the pattern.
  assign slen      = str_pending_q ? str_len_q : '0;
  assign total     = slen + pat_len_q;
  assign rd_idx    = (state_q == ARMED) ? len_t'(1) : ptr_q;
  assign rd_is_str = (rd_idx < slen);
  assign str_addr  = SAW'(rd_idx);
  assign pat_addr  = PAW'(rd_idx - slen);
  assign nxt_byte  = rd_is_str ? str_rd : pat_rd;

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (xfer && first_q),
    .wr_en_i  (xfer && !cur_pat),
    .wr_data_i(in_data),
    .rd_addr_i(str_addr),
    .rd_data_o(str_rd),
    .head_o   (str_head)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (xfer && first_q),
    .wr_en_i  (xfer && cur_pat),
    .wr_data_i(in_data),
    .rd_addr_i(pat_addr),
    .rd_data_o(pat_rd),
    .head_o   (pat_head)
  );

  // Byte 0 must coincide with the SME pulse itself, so it bypasses the output registers.
  assign launch    = (state_q == ARMED) && sme_valid;
  assign chardata  = launch ? (str_pending_q ? str_head : pat_head) : chardata_q;
  assign isstring  = (launch && str_pending_q) || isstring_q;
  assign ispattern = (launch && !str_pending_q) || ispattern_q;

  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign err_len   = err_len_q;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COLLECT;
      first_q       <= 1'b1;
      rec_pat_q     <= 1'b0;
      rec_len_q     <= '0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      str_pending_q <= 1'b0;
      ptr_q         <= '0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      err_len_q     <= 1'b0;
    end else begin
      err_len_q   <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (xfer) begin
            rec_len_q <= len_d;
            rec_pat_q <= cur_pat;
            first_q   <= in_last;
            if (in_last) begin
              if (len_d == lim) begin
                err_len_q <= 1'b1;
              end else if (cur_pat) begin
                pat_len_q <= len_d;
                state_q   <= ARMED;
              end else begin
                str_len_q     <= len_d;
                str_pending_q <= 1'b1;
              end
            end
          end
        end
        ARMED: begin
          if (sme_valid) begin
            if (total > len_t'(1)) begin
              chardata_q  <= nxt_byte;
              isstring_q  <= rd_is_str;
              ispattern_q <= !rd_is_str;
              ptr_q       <= len_t'(2);
              state_q     <= SEND;
            end else begin
              state_q <= WAIT_RES;
            end
          end
        end
        SEND: begin
          if (ptr_q < total) begin
            chardata_q  <= nxt_byte;
            isstring_q  <= rd_is_str;
            ispattern_q <= !rd_is_str;
            ptr_q       <= ptr_q + len_t'(1);
          end else begin
            chardata_q    <= '0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            str_pending_q <= 1'b0;
            state_q       <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (sme_valid) begin
            res_match_q <= sme_match;
            res_index_q <= sme_index;
            res_valid_q <= 1'b1;
            state_q     <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: record framing, burst replay, result forwarding, errors, reset.
`timescale 1ns/1ps
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_is_pat, in_last, sme_valid, sme_match;
  logic [7:0] in_data;
  logic [4:0] sme_index;
  logic       in_ready, isstring, ispattern, res_valid, res_match, err_len;
  logic [7:0] chardata;
  logic [4:0] res_index;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sme_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_is_pat(in_is_pat),
    .in_last  (in_last),
    .chardata (chardata),
    .isstring (isstring),
    .ispattern(ispattern),
    .sme_valid(sme_valid),
    .sme_match(sme_match),
    .sme_index(sme_index),
    .res_valid(res_valid),
    .res_match(res_match),
    .res_index(res_index),
    .err_len  (err_len)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_str(input string tag, input string got, input string exp);
    n_checks++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, got, exp);
    end
  endtask

  // Every cycle: inputs change 1ns after the rising edge, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rec(input string s, input bit is_pat);
    for (int i = 0; i < s.len(); i++) begin
      in_valid  = 1'b1;
      in_data   = s[i];
      in_is_pat = (i == 0) ? is_pat : !is_pat;
      in_last   = (i == s.len() - 1);
      if (i == 0) begin
        #1;
        check({"ready at record start \"", s, "\""}, in_ready, 1);
      end
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_is_pat = 1'b0;
    in_data   = 8'h00;
  endtask

  task automatic run_burst(input string tag, input string exp_s, input string exp_p);
    string got_b, got_t, exp_t;
    bit    both, rdy, quiet, done;
    got_b = ""; got_t = ""; exp_t = "";
    both = 1'b0; rdy = 1'b0; quiet = 1'b1; done = 1'b0;
    for (int i = 0; i < exp_s.len(); i++) exp_t = {exp_t, "s"};
    for (int i = 0; i < exp_p.len(); i++) exp_t = {exp_t, "p"};
    sme_valid = 1'b1;
    for (int c = 0; c < 48 && !done; c++) begin
      #1;
      if (in_ready) rdy = 1'b1;
      if (isstring && ispattern) both = 1'b1;
      if (isstring || ispattern) begin
        got_b = $sformatf("%s%c", got_b, chardata);
        if (isstring) got_t = {got_t, "s"};
        else          got_t = {got_t, "p"};
      end else begin
        done = 1'b1;
      end
      tick();
      sme_valid = 1'b0;
    end
    repeat (2) begin
      #1;
      if (isstring || ispattern || res_valid) quiet = 1'b0;
      if (in_ready) rdy = 1'b1;
      tick();
    end
    check_str({tag, " burst bytes"}, got_b, {exp_s, exp_p});
    check_str({tag, " burst strobes"}, got_t, exp_t);
    check({tag, " both strobes high"}, both, 0);
    check({tag, " in_ready during burst"}, rdy, 0);
    check({tag, " quiet after burst"}, quiet, 1);
  endtask

  task automatic give_result(input string tag, input bit m, input logic [4:0] idx);
    sme_valid = 1'b1;
    sme_match = m;
    sme_index = idx;
    #1;
    check({tag, " res_valid early"}, res_valid, 0);
    tick();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
    #1;
    check({tag, " res_valid"}, res_valid, 1);
    check({tag, " res_match"}, res_match, m);
    check({tag, " res_index"}, res_index, idx);
    check({tag, " in_ready back"}, in_ready, 1);
    tick();
    #1;
    check({tag, " res_valid one-shot"}, res_valid, 0);
    check({tag, " res_match held"}, res_match, m);
    check({tag, " res_index held"}, res_index, idx);
    tick();
  endtask

  task automatic stray(input string tag, input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      sme_valid = 1'b1;
      sme_match = 1'b1;
      sme_index = 5'd7;
      #1;
      if (isstring || ispattern || res_valid || !in_ready) bad = 1'b1;
      tick();
    end
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
    #1;
    if (res_valid) bad = 1'b1;
    check({tag, " stray sme_valid ignored"}, bad, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_is_pat = 1'b0;
    in_last   = 1'b0;
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset strobes", {isstring, ispattern}, 0);
    check("reset chardata", chardata, 0);
    check("reset results", {res_valid, res_match, res_index}, 0);
    check("reset err_len", err_len, 0);
    tick();

    // 1: string then pattern, burst on the first idle pulse.
    send_rec("ab cd", 1'b0);
    #1;
    check("t1 string err_len", err_len, 0);
    tick();
    send_rec("cd", 1'b1);
    #1;
    check("t1 armed in_ready", in_ready, 0);
    tick();
    run_burst("t1", "ab cd", "cd");
    give_result("t1", 1'b1, 5'd3);

    // 2: pattern-only burst reuses SME's stored string.
    send_rec("^x", 1'b1);
    tick();
    run_burst("t2", "", "^x");
    give_result("t2", 1'b0, 5'd0);

    // 3: over-length string and pattern are dropped.
    send_rec("abcdefghijklmnopqrstuvwxyz0123456", 1'b0);
    #1;
    check("t3 long string err_len", err_len, 1);
    check("t3 long string in_ready", in_ready, 1);
    tick();
    #1;
    check("t3 err_len one-shot", err_len, 0);
    tick();
    send_rec("^abcdefg$", 1'b1);
    #1;
    check("t3 long pattern err_len", err_len, 1);
    check("t3 long pattern stays collect", in_ready, 1);
    tick();
    stray("t3 no burst", 2);
    send_rec("ab", 1'b1);
    tick();
    run_burst("t3 no string pending", "", "ab");
    give_result("t3", 1'b1, 5'd0);

    // 4: stray pulses with and without a pending string.
    stray("t4 idle", 3);
    send_rec("hello", 1'b0);
    tick();
    stray("t4 pending string", 3);

    // 5: the newer string replaces the pending one.
    send_rec("zz", 1'b0);
    send_rec("z", 1'b1);
    #1;
    check("t5 armed in_ready", in_ready, 0);
    tick();
    stray_free_wait: begin end
    run_burst("t5", "zz", "z");
    give_result("t5", 1'b1, 5'd1);

    // Boundary: full-size string and pattern give the longest burst.
    send_rec("abcdefghijklmnopqrstuvwxyz012345", 1'b0);
    #1;
    check("max string err_len", err_len, 0);
    tick();
    send_rec("^012345$", 1'b1);
    #1;
    check("max pattern err_len", err_len, 0);
    tick();
    run_burst("max", "abcdefghijklmnopqrstuvwxyz012345", "^012345$");
    give_result("max", 1'b1, 5'd26);

    // 6: reset in the middle of a string burst.
    send_rec("qwerty", 1'b0);
    send_rec("ty", 1'b1);
    sme_valid = 1'b1;
    #1;
    check("t6 burst started", isstring, 1);
    tick();
    sme_valid = 1'b0;
    tick();
    tick();
    #1;
    check("t6 mid burst", {isstring, chardata}, {1'b1, 8'h72});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6 strobes after reset", {isstring, ispattern}, 0);
    check("t6 chardata after reset", chardata, 0);
    check("t6 in_ready after reset", in_ready, 1);
    tick();
    send_rec("mn", 1'b0);
    send_rec("n", 1'b1);
    tick();
    run_burst("t6 replay", "mn", "n");
    give_result("t6", 1'b1, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
